// File: rtl/l1v_geri_yaz_denetleyici.sv
// Set-associative write-back / write-allocate L1 data-cache controller with
// byte-masked stores, per-set round-robin replacement and full-cache flush.
module l1v_geri_yaz_denetleyici #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32,
   parameter int BLOK_BIT  = 128,
   parameter int SATIR     = 16,
   parameter int YOL       = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADRES_BIT-1:0]    port_istek_adres_i,
   input  logic                    port_istek_gecerli_i,
   input  logic                    port_istek_yaz_i,
   input  logic [VERI_BIT-1:0]     port_istek_veri_i,
   input  logic [VERI_BIT/8-1:0]   port_istek_maske_i,
   output logic                    port_istek_hazir_o,
   output logic [VERI_BIT-1:0]     port_veri_o,
   output logic                    port_veri_gecerli_o,
   input  logic                    port_veri_hazir_i,
   output logic [ADRES_BIT-1:0]    vy_istek_adres_o,
   output logic                    vy_istek_gecerli_o,
   input  logic                    vy_istek_hazir_i,
   output logic                    vy_istek_yaz_o,
   output logic [BLOK_BIT-1:0]     vy_istek_veri_o,
   input  logic [BLOK_BIT-1:0]     vy_veri_i,
   input  logic                    vy_veri_gecerli_i,
   output logic                    vy_veri_hazir_o,
   input  logic                    temizle_i,
   output logic                    temizle_bitti_o
);
   localparam int OFS    = $clog2(BLOK_BIT/8);
   localparam int IB     = $clog2(SATIR);
   localparam int TB     = ADRES_BIT - OFS - IB;
   localparam int YB     = $clog2(YOL);
   localparam int MB     = VERI_BIT/8;
   localparam int WOFS   = $clog2(MB);
   localparam int KELIME = BLOK_BIT/VERI_BIT;
   localparam int KB     = (KELIME > 1) ? $clog2(KELIME) : 1;

   typedef enum logic [2:0] {
      BOSTA, SORGU, YANIT, GERI_YAZ, DOLDUR_ISTEK, DOLDUR_BEKLE, TEMIZLE_TARA, TEMIZLE_YAZ
   } durum_t;

   durum_t               durum_q, durum_d;
   logic [ADRES_BIT-1:0] adres_q, adres_d;
   logic [VERI_BIT-1:0]  veri_q, veri_d;
   logic [MB-1:0]        maske_q, maske_d;
   logic                 yaz_q, yaz_d;
   logic [YB-1:0]        kurban_q, kurban_d;
   logic                 gecersiz_var_q, gecersiz_var_d;
   logic [VERI_BIT-1:0]  port_veri_q, port_veri_d;
   logic                 port_gecerli_q, port_gecerli_d;
   logic [ADRES_BIT-1:0] vy_adres_q, vy_adres_d;
   logic                 vy_gecerli_q, vy_gecerli_d;
   logic                 vy_yaz_q, vy_yaz_d;
   logic [BLOK_BIT-1:0]  vy_veri_q, vy_veri_d;
   logic                 vy_hazir_q, vy_hazir_d;
   logic                 bitti_q, bitti_d;
   logic [IB-1:0]        tara_set_q, tara_set_d;
   logic [YB-1:0]        tara_yol_q, tara_yol_d;
   logic [YOL-1:0]       gecerli_q [SATIR], gecerli_d [SATIR];
   logic [YOL-1:0]       kirli_q [SATIR], kirli_d [SATIR];
   logic [YB-1:0]        isaret_q [SATIR], isaret_d [SATIR];
   logic [TB-1:0]        tag_q [SATIR][YOL], tag_d [SATIR][YOL];
   logic [BLOK_BIT-1:0]  blok_q [SATIR][YOL], blok_d [SATIR][YOL];

   logic [IB-1:0]        idx;
   logic [TB-1:0]        etiket;
   logic [KB-1:0]        kelime_sec;
   logic                 isabet, gecersiz_var, tara_son, tara_ilerle;
   logic [YB-1:0]        isabet_yol, kurban;
   logic [BLOK_BIT-1:0]  isabet_blok, isabet_birlesik, dolgu_blok;
   logic                 unused_adres;

   function automatic logic [VERI_BIT-1:0] kelime_al(input logic [BLOK_BIT-1:0] blok,
                                                     input logic [KB-1:0] sec);
      logic [VERI_BIT-1:0] k;
      k = blok[VERI_BIT-1:0];
      for (int i = 1; i < KELIME; i++)
         if (sec == KB'(i)) k = blok[i*VERI_BIT +: VERI_BIT];
      return k;
   endfunction

   function automatic logic [BLOK_BIT-1:0] birlestir(input logic [BLOK_BIT-1:0] blok,
                                                     input logic [KB-1:0] sec,
                                                     input logic [VERI_BIT-1:0] veri,
                                                     input logic [MB-1:0] maske);
      logic [BLOK_BIT-1:0] s;
      s = blok;
      for (int i = 0; i < KELIME; i++)
         for (int b = 0; b < MB; b++)
            if (sec == KB'(i) && maske[b]) s[i*VERI_BIT + b*8 +: 8] = veri[b*8 +: 8];
      return s;
   endfunction

   assign idx          = adres_q[OFS +: IB];
   assign etiket       = adres_q[OFS+IB +: TB];
   assign kelime_sec   = (KELIME > 1) ? adres_q[WOFS +: KB] : '0;
   assign unused_adres = ^adres_q;
   assign gecersiz_var = ~&gecerli_q[idx];
   assign tara_son     = (tara_set_q == IB'(SATIR-1)) && (tara_yol_q == YB'(YOL-1));

   // Lowest invalid way wins the victim slot; otherwise the set's pointer decides.
   always_comb begin
      isabet     = 1'b0;
      isabet_yol = '0;
      kurban     = isaret_q[idx];
      for (int w = YOL-1; w >= 0; w--) begin
         if (gecerli_q[idx][w] && tag_q[idx][w] == etiket) begin
            isabet     = 1'b1;
            isabet_yol = YB'(w);
         end
         if (!gecerli_q[idx][w]) kurban = YB'(w);
      end
   end

   assign isabet_blok     = blok_q[idx][isabet_yol];
   assign isabet_birlesik = birlestir(isabet_blok, kelime_sec, veri_q, maske_q);
   assign dolgu_blok      = yaz_q ? birlestir(vy_veri_i, kelime_sec, veri_q, maske_q) : vy_veri_i;

   always_comb begin
      durum_d        = durum_q;
      adres_d        = adres_q;
      veri_d         = veri_q;
      maske_d        = maske_q;
      yaz_d          = yaz_q;
      kurban_d       = kurban_q;
      gecersiz_var_d = gecersiz_var_q;
      port_veri_d    = port_veri_q;
      port_gecerli_d = port_gecerli_q;
      vy_adres_d     = vy_adres_q;
      vy_gecerli_d   = vy_gecerli_q;
      vy_yaz_d       = vy_yaz_q;
      vy_veri_d      = vy_veri_q;
      vy_hazir_d     = vy_hazir_q;
      bitti_d        = 1'b0;
      tara_set_d     = tara_set_q;
      tara_yol_d     = tara_yol_q;
      gecerli_d      = gecerli_q;
      kirli_d        = kirli_q;
      isaret_d       = isaret_q;
      tag_d          = tag_q;
      blok_d         = blok_q;
      tara_ilerle    = 1'b0;
      case (durum_q)
         BOSTA: begin
            if (temizle_i) begin
               tara_set_d = '0;
               tara_yol_d = '0;
               durum_d    = TEMIZLE_TARA;
            end else if (port_istek_gecerli_i) begin
               adres_d = port_istek_adres_i;
               veri_d  = port_istek_veri_i;
               maske_d = port_istek_maske_i;
               yaz_d   = port_istek_yaz_i;
               durum_d = SORGU;
            end
         end
         SORGU: begin
            if (isabet) begin
               if (yaz_q) begin
                  blok_d[idx][isabet_yol]  = isabet_birlesik;
                  kirli_d[idx][isabet_yol] = 1'b1;
                  port_veri_d = kelime_al(isabet_birlesik, kelime_sec);
               end else begin
                  port_veri_d = kelime_al(isabet_blok, kelime_sec);
               end
               port_gecerli_d = 1'b1;
               durum_d        = YANIT;
            end else begin
               kurban_d       = kurban;
               gecersiz_var_d = gecersiz_var;
               vy_gecerli_d   = 1'b1;
               if (gecerli_q[idx][kurban] && kirli_q[idx][kurban]) begin
                  vy_yaz_d   = 1'b1;
                  vy_adres_d = {tag_q[idx][kurban], idx, {OFS{1'b0}}};
                  vy_veri_d  = blok_q[idx][kurban];
                  durum_d    = GERI_YAZ;
               end else begin
                  vy_yaz_d   = 1'b0;
                  vy_adres_d = {etiket, idx, {OFS{1'b0}}};
                  durum_d    = DOLDUR_ISTEK;
               end
            end
         end
         GERI_YAZ: begin
            if (vy_istek_hazir_i) begin
               kirli_d[idx][kurban_q] = 1'b0;
               vy_yaz_d   = 1'b0;
               vy_adres_d = {etiket, idx, {OFS{1'b0}}};
               durum_d    = DOLDUR_ISTEK;
            end
         end
         DOLDUR_ISTEK: begin
            if (vy_istek_hazir_i) begin
               vy_gecerli_d = 1'b0;
               vy_hazir_d   = 1'b1;
               durum_d      = DOLDUR_BEKLE;
            end
         end
         DOLDUR_BEKLE: begin
            if (vy_veri_gecerli_i) begin
               blok_d[idx][kurban_q]    = dolgu_blok;
               tag_d[idx][kurban_q]     = etiket;
               gecerli_d[idx][kurban_q] = 1'b1;
               kirli_d[idx][kurban_q]   = yaz_q;
               if (!gecersiz_var_q) isaret_d[idx] = isaret_q[idx] + YB'(1);
               vy_hazir_d     = 1'b0;
               port_veri_d    = kelime_al(dolgu_blok, kelime_sec);
               port_gecerli_d = 1'b1;
               durum_d        = YANIT;
            end
         end
         YANIT: begin
            if (port_veri_hazir_i) begin
               port_gecerli_d = 1'b0;
               durum_d        = BOSTA;
            end
         end
         TEMIZLE_TARA: begin
            if (gecerli_q[tara_set_q][tara_yol_q] && kirli_q[tara_set_q][tara_yol_q]) begin
               vy_gecerli_d = 1'b1;
               vy_yaz_d     = 1'b1;
               vy_adres_d   = {tag_q[tara_set_q][tara_yol_q], tara_set_q, {OFS{1'b0}}};
               vy_veri_d    = blok_q[tara_set_q][tara_yol_q];
               durum_d      = TEMIZLE_YAZ;
            end else begin
               tara_ilerle = 1'b1;
            end
         end
         TEMIZLE_YAZ: begin
            if (vy_istek_hazir_i) begin
               vy_gecerli_d = 1'b0;
               tara_ilerle  = 1'b1;
            end
         end
         default: durum_d = BOSTA;
      endcase
      // Retire the scanned entry and step to the next one (or finish the flush).
      if (tara_ilerle) begin
         gecerli_d[tara_set_q][tara_yol_q] = 1'b0;
         kirli_d[tara_set_q][tara_yol_q]   = 1'b0;
         if (tara_son) begin
            bitti_d = 1'b1;
            for (int s = 0; s < SATIR; s++) isaret_d[s] = '0;
            durum_d = BOSTA;
         end else begin
            {tara_set_d, tara_yol_d} = {tara_set_q, tara_yol_q} + (IB+YB)'(1);
            durum_d = TEMIZLE_TARA;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q        <= BOSTA;
         yaz_q          <= 1'b0;
         kurban_q       <= '0;
         gecersiz_var_q <= 1'b0;
         port_veri_q    <= '0;
         port_gecerli_q <= 1'b0;
         vy_adres_q     <= '0;
         vy_gecerli_q   <= 1'b0;
         vy_yaz_q       <= 1'b0;
         vy_veri_q      <= '0;
         vy_hazir_q     <= 1'b0;
         bitti_q        <= 1'b0;
         tara_set_q     <= '0;
         tara_yol_q     <= '0;
         for (int s = 0; s < SATIR; s++) begin
            gecerli_q[s] <= '0;
            kirli_q[s]   <= '0;
            isaret_q[s]  <= '0;
         end
      end else begin
         durum_q        <= durum_d;
         yaz_q          <= yaz_d;
         kurban_q       <= kurban_d;
         gecersiz_var_q <= gecersiz_var_d;
         port_veri_q    <= port_veri_d;
         port_gecerli_q <= port_gecerli_d;
         vy_adres_q     <= vy_adres_d;
         vy_gecerli_q   <= vy_gecerli_d;
         vy_yaz_q       <= vy_yaz_d;
         vy_veri_q      <= vy_veri_d;
         vy_hazir_q     <= vy_hazir_d;
         bitti_q        <= bitti_d;
         tara_set_q     <= tara_set_d;
         tara_yol_q     <= tara_yol_d;
         gecerli_q      <= gecerli_d;
         kirli_q        <= kirli_d;
         isaret_q       <= isaret_d;
      end
   end

   always_ff @(posedge clk_i) begin
      adres_q <= adres_d;
      veri_q  <= veri_d;
      maske_q <= maske_d;
      tag_q   <= tag_d;
      blok_q  <= blok_d;
   end

   assign port_istek_hazir_o  = (durum_q == BOSTA) && !temizle_i && !rst_i;
   assign port_veri_o         = port_veri_q;
   assign port_veri_gecerli_o = port_gecerli_q;
   assign vy_istek_adres_o    = vy_adres_q;
   assign vy_istek_gecerli_o  = vy_gecerli_q;
   assign vy_istek_yaz_o      = vy_yaz_q;
   assign vy_istek_veri_o     = vy_veri_q;
   assign vy_veri_hazir_o     = vy_hazir_q;
   assign temizle_bitti_o     = bitti_q;
endmodule

// File: tb/tb_l1v_geri_yaz_denetleyici.sv
// Directed bench for l1v_geri_yaz_denetleyici: table of port transactions with a
// bus responder that logs every bus handshake, plus flush and backpressure sequences.
module tb_l1v_geri_yaz_denetleyici;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  port_istek_adres_i;
   logic         port_istek_gecerli_i;
   logic         port_istek_yaz_i;
   logic [31:0]  port_istek_veri_i;
   logic [3:0]   port_istek_maske_i;
   logic         port_istek_hazir_o;
   logic [31:0]  port_veri_o;
   logic         port_veri_gecerli_o;
   logic         port_veri_hazir_i;
   logic [31:0]  vy_istek_adres_o;
   logic         vy_istek_gecerli_o;
   logic         vy_istek_hazir_i;
   logic         vy_istek_yaz_o;
   logic [127:0] vy_istek_veri_o;
   logic [127:0] vy_veri_i;
   logic         vy_veri_gecerli_i;
   logic         vy_veri_hazir_o;
   logic         temizle_i;
   logic         temizle_bitti_o;

   always #5 clk = ~clk;

   l1v_geri_yaz_denetleyici #(
      .ADRES_BIT(32), .VERI_BIT(32), .BLOK_BIT(128), .SATIR(16), .YOL(2)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .port_istek_adres_i(port_istek_adres_i), .port_istek_gecerli_i(port_istek_gecerli_i),
      .port_istek_yaz_i(port_istek_yaz_i), .port_istek_veri_i(port_istek_veri_i),
      .port_istek_maske_i(port_istek_maske_i), .port_istek_hazir_o(port_istek_hazir_o),
      .port_veri_o(port_veri_o), .port_veri_gecerli_o(port_veri_gecerli_o),
      .port_veri_hazir_i(port_veri_hazir_i),
      .vy_istek_adres_o(vy_istek_adres_o), .vy_istek_gecerli_o(vy_istek_gecerli_o),
      .vy_istek_hazir_i(vy_istek_hazir_i), .vy_istek_yaz_o(vy_istek_yaz_o),
      .vy_istek_veri_o(vy_istek_veri_o), .vy_veri_i(vy_veri_i),
      .vy_veri_gecerli_i(vy_veri_gecerli_i), .vy_veri_hazir_o(vy_veri_hazir_o),
      .temizle_i(temizle_i), .temizle_bitti_o(temizle_bitti_o)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
      total++;
      if (gercek !== beklenen) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", ad, gercek, beklenen);
      end
   endtask

   // Bus side: backing memory, request log and flush-done counter.
   logic [127:0] bellek [logic [31:0]];
   logic [31:0]  log_adr [$];
   logic         log_yaz [$];
   logic [127:0] log_veri [$];
   int           bitti_say = 0;
   logic         bekleyen = 1'b0;
   logic [31:0]  bekleyen_adr = '0;

   function automatic logic [127:0] blok_getir(input logic [31:0] a);
      if (bellek.exists(a)) return bellek[a];
      return {4{a}};
   endfunction

   initial begin
      vy_istek_hazir_i  = 1'b0;
      vy_veri_gecerli_i = 1'b0;
      vy_veri_i         = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            vy_istek_hazir_i  = 1'b0;
            vy_veri_gecerli_i = 1'b0;
            bekleyen          = 1'b0;
         end else begin
            if (bekleyen && vy_veri_hazir_o && !vy_veri_gecerli_i) begin
               vy_veri_gecerli_i = 1'b1;
               vy_veri_i         = blok_getir(bekleyen_adr);
               bekleyen          = 1'b0;
            end else begin
               vy_veri_gecerli_i = 1'b0;
            end
            if (vy_istek_gecerli_o && !vy_istek_hazir_i) begin
               vy_istek_hazir_i = 1'b1;
               log_adr.push_back(vy_istek_adres_o);
               log_yaz.push_back(vy_istek_yaz_o);
               log_veri.push_back(vy_istek_veri_o);
               if (vy_istek_yaz_o) bellek[vy_istek_adres_o] = vy_istek_veri_o;
               else begin
                  bekleyen     = 1'b1;
                  bekleyen_adr = vy_istek_adres_o;
               end
            end else begin
               vy_istek_hazir_i = 1'b0;
            end
            if (temizle_bitti_o) bitti_say++;
         end
      end
   end

   task automatic istek(input logic [31:0] adr, input logic yaz, input logic [31:0] veri,
                        input logic [3:0] maske, input int bp,
                        output logic [31:0] yanit, output int gec);
      logic ok;
      port_istek_adres_i   = adr;
      port_istek_yaz_i     = yaz;
      port_istek_veri_i    = veri;
      port_istek_maske_i   = maske;
      port_istek_gecerli_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         ok = port_istek_hazir_o;
         @(posedge clk); #1;
         if (ok) break;
      end
      port_istek_gecerli_i = 1'b0;
      chk("kabul_zaman", {127'd0, ok}, 128'd1);
      ok = 1'b0;
      gec = 0;
      for (int i = 1; i <= 100; i++) begin
         if (port_veri_gecerli_o) begin
            ok  = 1'b1;
            gec = i;
            break;
         end
         @(posedge clk); #1;
      end
      chk("yanit_zaman", {127'd0, ok}, 128'd1);
      yanit = port_veri_o;
      for (int j = 0; j < bp; j++) begin
         @(posedge clk); #1;
         chk("bp_veri_sabit", {96'd0, port_veri_o}, {96'd0, yanit});
         chk("bp_gecerli", {127'd0, port_veri_gecerli_o}, 128'd1);
         chk("bp_istek_hazir", {127'd0, port_istek_hazir_o}, 128'd0);
      end
      port_veri_hazir_i = 1'b1;
      @(posedge clk); #1;
      port_veri_hazir_i = 1'b0;
      if (bp > 0) chk("bp_sonra_hazir", {127'd0, port_istek_hazir_o}, 128'd1);
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        yaz;
      logic [31:0] veri;
      logic [3:0]  maske;
      logic [31:0] bek;
      int          gec;
      int          vy;
   } vek_t;

   vek_t tablo [12];

   initial begin
      logic [31:0] yanit;
      int gec, once;
      tablo[0]  = '{32'h100, 1'b0, 32'h0,        4'h0, 32'h11111111, 0, 1};
      tablo[1]  = '{32'h104, 1'b0, 32'h0,        4'h0, 32'h22222222, 2, 0};
      tablo[2]  = '{32'h104, 1'b1, 32'hAABBCCDD, 4'h3, 32'h2222CCDD, 2, 0};
      tablo[3]  = '{32'h104, 1'b0, 32'h0,        4'h0, 32'h2222CCDD, 2, 0};
      tablo[4]  = '{32'h10C, 1'b0, 32'h0,        4'h0, 32'h00000000, 2, 0};
      tablo[5]  = '{32'h200, 1'b0, 32'h0,        4'h0, 32'h77777777, 0, 1};
      tablo[6]  = '{32'h300, 1'b0, 32'h0,        4'h0, 32'hBBBBBBBB, 0, 2};
      tablo[7]  = '{32'h208, 1'b1, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2, 0};
      tablo[8]  = '{32'h400, 1'b0, 32'h0,        4'h0, 32'h00000400, 0, 2};
      tablo[9]  = '{32'h500, 1'b1, 32'h12345678, 4'hC, 32'h12340500, 0, 1};
      tablo[10] = '{32'h110, 1'b1, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 0, 1};
      tablo[11] = '{32'h40C, 1'b0, 32'h0,        4'h0, 32'h00000400, 2, 0};
      bellek[32'h100] = 128'h00000000_33333333_22222222_11111111;
      bellek[32'h200] = 128'h44444444_55555555_66666666_77777777;
      bellek[32'h300] = 128'h88888888_99999999_AAAAAAAA_BBBBBBBB;

      rst = 1'b1;
      port_istek_adres_i = '0; port_istek_gecerli_i = 1'b0; port_istek_yaz_i = 1'b0;
      port_istek_veri_i = '0; port_istek_maske_i = '0; port_veri_hazir_i = 1'b0;
      temizle_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cikislar", {121'd0, port_istek_hazir_o, port_veri_gecerli_o, vy_istek_gecerli_o,
                             vy_istek_yaz_o, vy_veri_hazir_o, temizle_bitti_o, |port_veri_o}, 128'd0);
      chk("reset_vy_adres", {96'd0, vy_istek_adres_o}, 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_sonra_hazir", {127'd0, port_istek_hazir_o}, 128'd1);

      for (int k = 0; k < 12; k++) begin
         once = log_adr.size();
         istek(tablo[k].adr, tablo[k].yaz, tablo[k].veri, tablo[k].maske, 0, yanit, gec);
         chk($sformatf("v%0d_veri", k), {96'd0, yanit}, {96'd0, tablo[k].bek});
         if (tablo[k].gec != 0) chk($sformatf("v%0d_gecikme", k), 128'(gec), 128'(tablo[k].gec));
         chk($sformatf("v%0d_vy_sayi", k), 128'(log_adr.size() - once), 128'(tablo[k].vy));
      end

      chk("oku_0x100_adr", {96'd0, log_adr[0]}, 128'h100);
      chk("oku_0x100_yaz", {127'd0, log_yaz[0]}, 128'd0);
      chk("tahliye_0x100_adr", {96'd0, log_adr[2]}, 128'h100);
      chk("tahliye_0x100_yaz", {127'd0, log_yaz[2]}, 128'd1);
      chk("tahliye_0x100_veri", log_veri[2], 128'h00000000_33333333_2222CCDD_11111111);
      chk("sonra_oku_0x300", {95'd0, log_yaz[3], log_adr[3]}, {95'd0, 1'b0, 32'h300});
      chk("tahliye_0x200_veri", log_veri[4], 128'h44444444_DEADBEEF_66666666_77777777);
      chk("tahliye_0x200_adr", {95'd0, log_yaz[4], log_adr[4]}, {95'd0, 1'b1, 32'h200});

      istek(32'h500, 1'b0, 32'h0, 4'h0, 3, yanit, gec);
      chk("bp_yanit", {96'd0, yanit}, 128'h12340500);

      once = log_adr.size();
      port_istek_adres_i   = 32'h104;
      port_istek_yaz_i     = 1'b0;
      port_istek_gecerli_i = 1'b1;
      temizle_i            = 1'b1;
      #1;
      chk("temizle_istek_hazir", {127'd0, port_istek_hazir_o}, 128'd0);
      @(posedge clk); #1;
      temizle_i            = 1'b0;
      port_istek_gecerli_i = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (bitti_say > 0) break;
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("temizle_bitti_sayi", 128'(bitti_say), 128'd1);
      chk("temizle_vy_sayi", 128'(log_adr.size() - once), 128'd2);
      chk("temizle_yaz0", {95'd0, log_yaz[once], log_adr[once]}, {95'd0, 1'b1, 32'h500});
      chk("temizle_veri0", log_veri[once], 128'h00000500_00000500_00000500_12340500);
      chk("temizle_yaz1", {95'd0, log_yaz[once+1], log_adr[once+1]}, {95'd0, 1'b1, 32'h110});
      chk("temizle_veri1", log_veri[once+1], 128'h00000110_00000110_00000110_CAFEF00D);
      chk("temizle_yanit_yok", {127'd0, port_veri_gecerli_o}, 128'd0);

      once = log_adr.size();
      istek(32'h400, 1'b0, 32'h0, 4'h0, 0, yanit, gec);
      chk("temiz_sonra_veri", {96'd0, yanit}, 128'h00000400);
      chk("temiz_sonra_iska", 128'(log_adr.size() - once), 128'd1);
      chk("temiz_sonra_oku", {95'd0, log_yaz[once], log_adr[once]}, {95'd0, 1'b0, 32'h400});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/l1v_geri_yaz_denetleyici.md
Name: l1v_geri_yaz_denetleyici

Overview:
- Parametrised set-associative L1 data-cache controller, write-back and write-allocate, with byte-masked stores and a full-cache flush.
- Sits between the core load/store port and the bus (veri yolu) controller.
- Tag, valid and dirty state and the data blocks are held internally in flops; replacement is per-set round-robin.
- Successor to the read-only L1 controller: adds stores, dirty eviction, per-set replacement and flush.

Parameters:
ADRES_BIT, 32, address width
VERI_BIT, 32, port word width (multiple of 8)
BLOK_BIT, 128, cache block width (power of 2, at least VERI_BIT)
SATIR, 16, sets (power of 2)
YOL, 2, ways (power of 2, at least 2)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
port_istek_adres_i  in  ADRES_BIT  request address; low log2(VERI_BIT/8) bits ignored
port_istek_gecerli_i  in  1  request valid
port_istek_yaz_i  in  1  1 = store, 0 = load
port_istek_veri_i  in  VERI_BIT  store data
port_istek_maske_i  in  VERI_BIT/8  store byte enables
port_istek_hazir_o  out  1  request ready
port_veri_o  out  VERI_BIT  response word
port_veri_gecerli_o  out  1  response valid
port_veri_hazir_i  in  1  response ready
vy_istek_adres_o  out  ADRES_BIT  block-aligned bus address
vy_istek_gecerli_o  out  1  bus request valid
vy_istek_hazir_i  in  1  bus request ready
vy_istek_yaz_o  out  1  1 = writeback, 0 = fill read
vy_istek_veri_o  out  BLOK_BIT  writeback block
vy_veri_i  in  BLOK_BIT  fill block
vy_veri_gecerli_i  in  1  fill valid
vy_veri_hazir_o  out  1  fill ready
temizle_i  in  1  flush request, level-sampled in BOSTA
temizle_bitti_o  out  1  one-cycle flush-done pulse

Behaviour:
- Reset and clock: one clock domain; reset is asynchronous and active-high.
- Reset effect: every output is 0, all valid/dirty bits and round-robin pointers are 0, state is BOSTA. Block/tag contents are don't-care.
- Reset mid-operation abandons the transaction; vy_istek_gecerli_o and port_veri_gecerli_o drop asynchronously.
- Address split: offset = log2(BLOK_BIT/8) bits; index = next log2(SATIR) bits; tag = remainder.
- Bus addresses carry a zero offset.
- port_istek_hazir_o = (state==BOSTA) && !temizle_i.
- A request is accepted on gecerli&&hazir; address, data, mask and type are latched.
- States: BOSTA, SORGU, YANIT, GERI_YAZ, DOLDUR_ISTEK, DOLDUR_BEKLE, TEMIZLE_TARA, TEMIZLE_YAZ.
- SORGU (cycle after accept): compare tag against every valid way of the set.
  - Hit, load: selected word goes to port_veri_o, which is registered.
  - Hit, store: bytes with mask=1 are merged into the block, dirty is set, and port_veri_o is the merged word.
  - Either hit: go to YANIT, so port_veri_gecerli_o is high the cycle after SORGU (2-cycle hit latency).
- Miss, victim selection: lowest-index invalid way, else the per-set pointer.
  - Victim valid and dirty: go to GERI_YAZ.
  - Otherwise: go to DOLDUR_ISTEK.
- GERI_YAZ:
  - Drive vy_istek_gecerli_o=1, vy_istek_yaz_o=1, adres={victim tag, index, 0}, veri=victim block; hold stable until vy_istek_hazir_i.
  - On handshake, clear dirty and go to DOLDUR_ISTEK.
  - No response is expected for a writeback.
- DOLDUR_ISTEK: yaz=0, block-aligned request address; on handshake go to DOLDUR_BEKLE with vy_veri_hazir_o=1.
- DOLDUR_BEKLE: on vy_veri_gecerli_i:
  - Write block and tag, set valid.
  - Store miss: merge the store and set dirty.
  - Advance this set's pointer modulo YOL (only when no invalid way existed).
  - Drop vy_veri_hazir_o and go to YANIT with the word.
- YANIT:
  - port_veri_o and port_veri_gecerli_o are held stable until port_veri_hazir_i.
  - Return to BOSTA the cycle after the handshake.
- Flush, entry: temizle_i high in BOSTA has priority over a simultaneous port request, which is not accepted. The controller goes to TEMIZLE_TARA.
- TEMIZLE_TARA:
  - Scans set 0..SATIR-1 and way 0..YOL-1, one entry per cycle.
  - Dirty&valid entries go to TEMIZLE_YAZ (same handshake as GERI_YAZ), then resume at the next entry.
  - Every scanned entry is invalidated and cleaned.
- Flush, completion: after the last entry, temizle_bitti_o pulses for 1 cycle and the state returns to BOSTA. Pointers are reset to 0.
- Bus writes always complete before any fill read is issued; at most one bus request is outstanding.

Test Plan:
- Cold load miss: reset, then load 0x100. Required: one vy read at 0x100, yaz=0. Supply block 0x00000000_33333333_22222222_11111111. Required: port_veri_o=0x11111111, valid until hazir.
- Load hit: after the above, load 0x104. Required: port_veri_gecerli_o 2 cycles after accept, data 0x22222222, no vy activity.
- Masked store hit: store 0x104, data 0xAABBCCDD, mask 0011. Required: response 0x2222CCDD; a subsequent load of 0x104 returns 0x2222CCDD.
- Dirty eviction (YOL=2): fill 0x100 (dirty) and 0x200, then load 0x300. Required:
  - the pointer selects way 0, so the vy write to 0x100 carries the merged block;
  - the write precedes the vy read of 0x300.
- Backpressure: hold port_veri_hazir_i=0 for 3 cycles on a hit. Required: port_veri_o is stable; port_istek_hazir_o stays 0 until 1 cycle after the handshake.
- Flush: two dirty lines plus one clean line, then temizle_i=1 together with a port request. Required:
  - the request is not accepted;
  - exactly 2 vy writes occur;
  - temizle_bitti_o pulses once;
  - a subsequent load of the clean address misses.
